// File: rtl/bsg_tag_packet_tx.sv
// bsg_tag_packet_tx
// Host-side serializer for the bsg_tag protocol. Takes one parallel command
// per valid/ready handshake and shifts it out one bit per clk_i cycle on
// tag_data_o, framed by tag_en_o. A command is either a normal tag packet
// (header then payload) or the long run of ones that resets the tag master.
// Every command is followed by gap_p zero bits with tag_en_o still high.
// tag_en_o and tag_data_o come straight from flops, so the first bit shows up
// in the cycle after the acceptance edge.

module bsg_tag_packet_tx #(
  parameter int els_p        = 8,
  parameter int lg_width_p   = 4,
  parameter int reset_ones_p = 40,
  parameter int gap_p        = 2,
  localparam int lg_els_lp   = $clog2(els_p),
  localparam int mpw_lp      = (1 << lg_width_p) - 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  v_i,
  output logic                  ready_and_o,
  input  logic                  cmd_reset_i,
  input  logic [lg_els_lp-1:0]  node_id_i,
  input  logic                  data_not_reset_i,
  input  logic [lg_width_p-1:0] len_i,
  input  logic [mpw_lp-1:0]     payload_i,
  output logic                  tag_en_o,
  output logic                  tag_data_o,
  output logic                  busy_o
);

  // Header is valid bit + length + data_not_reset + node id.
  localparam int hdr_bits_lp = 2 + lg_width_p + lg_els_lp;

  // Bits still queued behind the one currently on the wire.
  localparam int shift_w_lp = hdr_bits_lp + mpw_lp - 1;

  // The bit counter must hold the longest run spent in any single state.
  localparam int max_a_lp   = (reset_ones_p > hdr_bits_lp) ? reset_ones_p : hdr_bits_lp;
  localparam int max_b_lp   = (mpw_lp > gap_p) ? mpw_lp : gap_p;
  localparam int cnt_max_lp = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;
  localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);

  // The counter holds the number of cycles left in the state after the
  // current one, so each state entry loads (length - 1).
  localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] cnt_rst_lp = cnt_w_lp'(reset_ones_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_hdr_lp = cnt_w_lp'(hdr_bits_lp - 1);
  localparam logic [cnt_w_lp-1:0] cnt_gap_lp = cnt_w_lp'(gap_p - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_HDR,
    S_PAY,
    S_GAP
  } state_e;

  state_e                  r_state;
  state_e                  w_next_state;
  logic [cnt_w_lp-1:0]     r_cnt;
  logic [cnt_w_lp-1:0]     w_next_cnt;
  logic [shift_w_lp-1:0]   r_shift;
  logic [shift_w_lp-1:0]   w_next_shift;
  logic [lg_width_p-1:0]   r_len;
  logic [lg_width_p-1:0]   w_next_len;
  logic                    r_ready;
  logic                    w_next_ready;
  logic                    r_tag_en;
  logic                    w_next_en;
  logic                    r_tag_data;
  logic                    w_next_data;
  logic [shift_w_lp:0]     w_load;

  // Whole packet laid out LSB-first in wire order: bit 0 goes out first.
  assign w_load = {payload_i, node_id_i, data_not_reset_i, len_i, 1'b1};

  // Next-state, counter, shifter and next output bit for every state.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_shift = r_shift;
    w_next_len   = r_len;
    w_next_en    = 1'b0;
    w_next_data  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (v_i && r_ready) begin
          w_next_en = 1'b1;
          if (cmd_reset_i) begin
            w_next_state = S_RST;
            w_next_cnt   = cnt_rst_lp;
            w_next_data  = 1'b1;
          end else begin
            w_next_state = S_HDR;
            w_next_cnt   = cnt_hdr_lp;
            w_next_shift = w_load[shift_w_lp:1];
            w_next_len   = len_i;
            w_next_data  = w_load[0];
          end
        end
      end

      S_RST: begin
        w_next_en = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = S_GAP;
          w_next_cnt   = cnt_gap_lp;
        end else begin
          w_next_cnt  = r_cnt - cnt_one_lp;
          w_next_data = 1'b1;
        end
      end

      S_HDR: begin
        w_next_en = 1'b1;
        if (r_cnt == '0) begin
          if (r_len != '0) begin
            w_next_state = S_PAY;
            w_next_cnt   = cnt_w_lp'(r_len) - cnt_one_lp;
            w_next_data  = r_shift[0];
            w_next_shift = r_shift >> 1;
          end else begin
            w_next_state = S_GAP;
            w_next_cnt   = cnt_gap_lp;
          end
        end else begin
          w_next_cnt   = r_cnt - cnt_one_lp;
          w_next_data  = r_shift[0];
          w_next_shift = r_shift >> 1;
        end
      end

      S_PAY: begin
        w_next_en = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = S_GAP;
          w_next_cnt   = cnt_gap_lp;
        end else begin
          w_next_cnt   = r_cnt - cnt_one_lp;
          w_next_data  = r_shift[0];
          w_next_shift = r_shift >> 1;
        end
      end

      S_GAP: begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_en  = 1'b1;
          w_next_cnt = r_cnt - cnt_one_lp;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Ready is registered so it stays low through reset and rises one edge later.
  assign w_next_ready = (w_next_state == S_IDLE);

  // State, datapath and registered outputs; reset discards any in-flight command.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_len      <= '0;
      r_ready    <= 1'b0;
      r_tag_en   <= 1'b0;
      r_tag_data <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_shift    <= w_next_shift;
      r_len      <= w_next_len;
      r_ready    <= w_next_ready;
      r_tag_en   <= w_next_en;
      r_tag_data <= w_next_data;
    end
  end

  assign ready_and_o = r_ready;
  assign busy_o      = reset_n_i & ~r_ready;
  assign tag_en_o    = r_tag_en;
  assign tag_data_o  = r_tag_data;

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// tb_bsg_tag_packet_tx
// Drives commands into bsg_tag_packet_tx and records the serial stream while
// tag_en_o is high. Each stream is compared against a reference built directly
// from the wire format (header fields LSB-first, payload, gap zeros).

module tb_bsg_tag_packet_tx;

  localparam int ELS   = 8;
  localparam int LGW   = 4;
  localparam int RONES = 40;
  localparam int GAP   = 2;
  localparam int LGE   = 3;
  localparam int MPW   = 15;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          v_i = 1'b0;
  logic          ready_and_o;
  logic          cmd_reset_i = 1'b0;
  logic [LGE-1:0] node_id_i = '0;
  logic          data_not_reset_i = 1'b0;
  logic [LGW-1:0] len_i = '0;
  logic [MPW-1:0] payload_i = '0;
  logic          tag_en_o;
  logic          tag_data_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] obs_vec;
  logic [127:0] exp_vec;
  int           obs_len;
  int           exp_len;

  always #5 clk_i = ~clk_i;

  bsg_tag_packet_tx #(
    .els_p        (ELS),
    .lg_width_p   (LGW),
    .reset_ones_p (RONES),
    .gap_p        (GAP)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .v_i              (v_i),
    .ready_and_o      (ready_and_o),
    .cmd_reset_i      (cmd_reset_i),
    .node_id_i        (node_id_i),
    .data_not_reset_i (data_not_reset_i),
    .len_i            (len_i),
    .payload_i        (payload_i),
    .tag_en_o         (tag_en_o),
    .tag_data_o       (tag_data_o),
    .busy_o           (busy_o)
  );

  // Reference stream for one command, straight from the wire format.
  task automatic build_expected(input logic cr, input logic [LGE-1:0] node, input logic dnr,
                                input logic [LGW-1:0] len, input logic [MPW-1:0] pay);
    logic q[$];
    q = {};
    if (cr) begin
      for (int i = 0; i < RONES; i++) q.push_back(1'b1);
    end else begin
      q.push_back(1'b1);
      for (int i = 0; i < LGW; i++) q.push_back(len[i]);
      q.push_back(dnr);
      for (int i = 0; i < LGE; i++) q.push_back(node[i]);
      for (int i = 0; i < int'(len); i++) q.push_back(pay[i]);
    end
    for (int i = 0; i < GAP; i++) q.push_back(1'b0);
    exp_vec = '0;
    exp_len = q.size();
    for (int i = 0; i < exp_len; i++) exp_vec[i] = q[i];
  endtask

  // Garbage on the command inputs once a command has been taken.
  task automatic scramble();
    cmd_reset_i      = 1'($urandom);
    node_id_i        = LGE'($urandom);
    data_not_reset_i = 1'($urandom);
    len_i            = LGW'($urandom);
    payload_i        = MPW'($urandom);
  endtask

  // Called at a negedge; returns at the negedge where the first bit is visible.
  task automatic send_cmd(input logic cr, input logic [LGE-1:0] node, input logic dnr,
                          input logic [LGW-1:0] len, input logic [MPW-1:0] pay);
    int waited;
    cmd_reset_i      = cr;
    node_id_i        = node;
    data_not_reset_i = dnr;
    len_i            = len;
    payload_i        = pay;
    v_i              = 1'b1;
    waited           = 0;
    while (ready_and_o !== 1'b1 && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    if (waited >= 200) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL send_timeout: ready_and_o got %b expected 1", ready_and_o);
      v_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0;
    scramble();
  endtask

  // Records tag_data_o on every negedge while tag_en_o is high (bounded).
  task automatic capture();
    obs_vec = '0;
    obs_len = 0;
    while (tag_en_o === 1'b1 && obs_len < 100) begin
      obs_vec[obs_len] = tag_data_o;
      obs_len++;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    v_i = 1'b1;
    scramble();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_tests++;
      if ({tag_en_o, tag_data_o, ready_and_o, busy_o} !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cycle %0d: got en/data/rdy/busy=%b expected 0000", c,
                 {tag_en_o, tag_data_o, ready_and_o, busy_o});
      end
    end
    reset_n_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({ready_and_o, busy_o, tag_en_o} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got rdy/busy/en=%b expected 100", {ready_and_o, busy_o, tag_en_o});
    end
    v_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (tag_en_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_no_accept: got tag_en_o=%b expected 0", tag_en_o);
    end
  endtask

  task automatic test_spec_packet();
    @(negedge clk_i);
    send_cmd(1'b0, 3'd5, 1'b1, 4'd3, 15'b101);
    capture();
    n_tests++;
    if (obs_len !== 14) begin
      n_fail++;
      $display("[TB] FAIL spec_pkt_len: got %0d enable cycles expected 14", obs_len);
    end
    n_tests++;
    if (obs_vec !== 128'b00101101100111) begin
      n_fail++;
      $display("[TB] FAIL spec_pkt_bits: got %h expected %h", obs_vec, 128'b00101101100111);
    end
    n_tests++;
    if ({ready_and_o, busy_o} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL spec_pkt_ready: got rdy/busy=%b expected 10", {ready_and_o, busy_o});
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk_i);
    send_cmd(1'b0, 3'd0, 1'b0, 4'd0, MPW'($urandom));
    capture();
    n_tests++;
    if (obs_len !== 11) begin
      n_fail++;
      $display("[TB] FAIL len0_len: got %0d enable cycles expected 11", obs_len);
    end
    n_tests++;
    if (obs_vec !== 128'b1) begin
      n_fail++;
      $display("[TB] FAIL len0_bits: got %h expected %h", obs_vec, 128'b1);
    end
    n_tests++;
    if (ready_and_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL len0_ready: got %b expected 1", ready_and_o);
    end
  endtask

  task automatic test_reset_cmd();
    logic [LGE-1:0] node;
    logic [LGW-1:0] len;
    logic [MPW-1:0] pay;
    logic           dnr;
    node = LGE'($urandom);
    len  = LGW'($urandom);
    pay  = MPW'($urandom);
    dnr  = 1'($urandom);
    @(negedge clk_i);
    build_expected(1'b1, node, dnr, len, pay);
    send_cmd(1'b1, node, dnr, len, pay);
    capture();
    n_tests++;
    if (obs_len !== exp_len) begin
      n_fail++;
      $display("[TB] FAIL rstcmd_len: got %0d enable cycles expected %0d", obs_len, exp_len);
    end
    n_tests++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("[TB] FAIL rstcmd_bits: got %h expected %h", obs_vec, exp_vec);
    end
    n_tests++;
    if (ready_and_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstcmd_ready: got %b expected 1", ready_and_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [LGE-1:0] b_node;
    logic [LGW-1:0] b_len;
    logic [MPW-1:0] b_pay;
    logic           b_dnr;
    int             waited;
    b_node = LGE'($urandom);
    b_len  = LGW'($urandom);
    b_pay  = MPW'($urandom);
    b_dnr  = 1'($urandom);
    @(negedge clk_i);
    cmd_reset_i      = 1'b0;
    node_id_i        = 3'd7;
    data_not_reset_i = 1'b1;
    len_i            = 4'd15;
    payload_i        = 15'h7FFF;
    v_i              = 1'b1;
    waited           = 0;
    while (ready_and_o !== 1'b1 && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_reset_i      = 1'b0;
    node_id_i        = b_node;
    data_not_reset_i = b_dnr;
    len_i            = b_len;
    payload_i        = b_pay;
    capture();
    n_tests++;
    if (obs_len !== 26) begin
      n_fail++;
      $display("[TB] FAIL maxpay_len: got %0d enable cycles expected 26", obs_len);
    end
    n_tests++;
    if (obs_vec !== 128'h0FFFFFF) begin
      n_fail++;
      $display("[TB] FAIL maxpay_bits: got %h expected %h", obs_vec, 128'h0FFFFFF);
    end
    n_tests++;
    if ({tag_en_o, ready_and_o} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle: got en/rdy=%b expected 01", {tag_en_o, ready_and_o});
    end
    @(negedge clk_i);
    v_i = 1'b0;
    scramble();
    build_expected(1'b0, b_node, b_dnr, b_len, b_pay);
    capture();
    n_tests++;
    if (obs_len !== exp_len) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_len: got %0d enable cycles expected %0d", obs_len, exp_len);
    end
    n_tests++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_bits: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    logic           cr;
    logic [LGE-1:0] node;
    logic [LGW-1:0] len;
    logic [MPW-1:0] pay;
    logic           dnr;
    for (int k = 0; k < 16; k++) begin
      cr   = ($urandom_range(0, 7) == 0);
      node = LGE'($urandom);
      len  = LGW'($urandom);
      pay  = MPW'($urandom);
      dnr  = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      build_expected(cr, node, dnr, len, pay);
      send_cmd(cr, node, dnr, len, pay);
      capture();
      n_tests++;
      if (obs_len !== exp_len) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_len: got %0d enable cycles expected %0d", k, obs_len, exp_len);
      end
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_bits: got %h expected %h", k, obs_vec, exp_vec);
      end
      n_tests++;
      if (ready_and_o !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_ready: got %b expected 1", k, ready_and_o);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [LGE-1:0] node;
    logic [MPW-1:0] pay;
    @(negedge clk_i);
    send_cmd(1'b0, LGE'($urandom), 1'b1, 4'd8, MPW'($urandom));
    repeat (11) @(negedge clk_i);
    n_tests++;
    if (tag_en_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_active: got tag_en_o=%b expected 1", tag_en_o);
    end
    #1;
    reset_n_i = 1'b0;
    #1;
    n_tests++;
    if ({tag_en_o, tag_data_o, ready_and_o, busy_o} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL midrst_async: got en/data/rdy/busy=%b expected 0000",
               {tag_en_o, tag_data_o, ready_and_o, busy_o});
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_tests++;
      if ({tag_en_o, ready_and_o} !== 2'b01) begin
        n_fail++;
        $display("[TB] FAIL midrst_quiet cycle %0d: got en/rdy=%b expected 01", c, {tag_en_o, ready_and_o});
      end
    end
    node = LGE'($urandom);
    pay  = MPW'($urandom);
    build_expected(1'b0, node, 1'b1, 4'd6, pay);
    send_cmd(1'b0, node, 1'b1, 4'd6, pay);
    capture();
    n_tests++;
    if (obs_len !== exp_len) begin
      n_fail++;
      $display("[TB] FAIL midrst_next_len: got %0d enable cycles expected %0d", obs_len, exp_len);
    end
    n_tests++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("[TB] FAIL midrst_next_bits: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_spec_packet();
    test_len_zero();
    test_reset_cmd();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
